hilo_mul_sequencer: RTL and testbench

- Owns the HI/LO register pair and runs a multi-cycle, radix-2 shift-add multiplier for mult, multu, madd and msub.
- Also performs single-cycle mthi/mtlo writes.
- Sits beside the single-cycle ALU in EX. It takes multiply work off the ALU and drives Busy so the hazard unit stalls mfhi/mflo and further HI/LO ops until the result is committed.

---
 rtl/hilo_mul_sequencer_pkg.sv | 27 ++
 rtl/hilo_mul_sequencer_if.sv | 30 +++
 rtl/hilo_mul_sequencer_shiftadd_mul_core.sv | 84 ++++++++
 rtl/hilo_mul_sequencer.sv | 137 +++++++++++++
 tb/tb_hilo_mul_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_mul_sequencer_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply sequencer.
//   - op_e    : operation codes presented on the Op bus
//   - state_e : sequencer FSM states
//   - DEFAULT_WIDTH / DEFAULT_CNT_W : default operand and counter widths
package hilo_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MADD  = 3'd3,
    OP_MSUB  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_mul_sequencer_if.sv
// hilo_mul_sequencer_if: request/result bundle between the EX stage and the
// HI/LO multiply sequencer.
//   Start, Op, A, B, Flush : request side, driven by the master (EX/hazard logic)
//   Busy, Done             : sequencer status, driven by the slave
//   HI_out, LO_out         : current HI/LO register contents
interface hilo_mul_sequencer_if #(
  parameter int WIDTH = hilo_pkg::DEFAULT_WIDTH
);

  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI_out;
  logic [WIDTH-1:0] LO_out;

  modport master (
    output Start, Op, A, B, Flush,
    input  Busy, Done, HI_out, LO_out
  );

  modport slave (
    input  Start, Op, A, B, Flush,
    output Busy, Done, HI_out, LO_out
  );

endinterface

// File: rtl/hilo_mul_sequencer_shiftadd_mul_core.sv
// shiftadd_mul_core: radix-2 shift-add datapath for an unsigned WIDTH x WIDTH
// multiply producing a 2*WIDTH result.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_load       : capture multiplicand/multiplier, clear accumulator and counter
//   i_step       : perform one add-and-shift iteration
//   i_mcand      : multiplicand (unsigned magnitude)
//   i_mplier     : multiplier (unsigned magnitude)
//   o_acc        : 2*WIDTH accumulator (the product once finished)
//   o_last       : the iteration taken on this step is the final one
// Build option EARLY_TERM_EN: when the remaining multiplier bits are zero the
// accumulator is shifted by the remaining count in one step and o_last rises.
module shiftadd_mul_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_acc,
  output logic               o_last
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH:0]     w_upperSum;
  logic [2*WIDTH-1:0] w_accStep;
  logic               w_cntLast;

  // Upper half plus multiplicand keeps its carry; it becomes the new top
  // WIDTH+1 bits after the right shift.
  assign w_upperSum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_accStep  = {w_upperSum, r_acc[WIDTH-1:1]};
  assign w_cntLast  = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef EARLY_TERM_EN
  logic             w_mplierZero;
  logic [CNT_W:0]   w_remain;

  assign w_mplierZero = (r_mplier == '0);
  assign w_remain     = (CNT_W+1)'(WIDTH) - {1'b0, r_cnt};
  assign o_last       = w_cntLast | w_mplierZero;
`else
  assign o_last       = w_cntLast;
`endif

  assign o_acc = r_acc;

  // Load clears the accumulator; each step adds (if the multiplier LSB is
  // set) and shifts accumulator and multiplier right by one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= i_mcand;
      r_mplier <= i_mplier;
      r_cnt    <= '0;
    end else if (i_step) begin
`ifdef EARLY_TERM_EN
      // Nothing left to add: jump straight to the fully shifted result.
      if (w_mplierZero) begin
        r_acc <= r_acc >> w_remain;
      end else begin
        r_acc <= w_accStep;
      end
`else
      r_acc    <= w_accStep;
`endif
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hilo_mul_sequencer.sv
// hilo_mul_sequencer: owns the HI/LO register pair and sequences multi-cycle
// mult/multu/madd/msub through a shift-add core; mthi/mtlo are single-cycle.
//   Clk    : clock, rising-edge
//   Reset  : asynchronous active-high reset
//   bus    : hilo_mul_sequencer_if.slave
//            Start/Op/A/B/Flush in, Busy/Done/HI_out/LO_out out
// Build option EARLY_TERM_EN: data-dependent latency (see shiftadd_mul_core).
module hilo_mul_sequencer
  import hilo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                  Clk,
  input  logic                  Reset,
  hilo_mul_sequencer_if.slave   bus
);

  state_e             r_state;
  op_e                r_op;
  logic               r_negate;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_mulOp;
  logic               w_signedOp;
  logic               w_negate;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic               w_load;
  logic               w_step;
  logic [2*WIDTH-1:0] w_acc;
  logic               w_last;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_commit;

  assign w_mulOp    = (bus.Op == OP_MULT) || (bus.Op == OP_MULTU) ||
                      (bus.Op == OP_MADD) || (bus.Op == OP_MSUB);
  assign w_signedOp = (bus.Op == OP_MULT) || (bus.Op == OP_MADD) ||
                      (bus.Op == OP_MSUB);

  // Magnitudes for signed ops; the most negative value maps to 2^(WIDTH-1),
  // which is exactly what the wrapped negate yields when read unsigned.
  assign w_magA   = (w_signedOp && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign w_magB   = (w_signedOp && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  assign w_negate = w_signedOp && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);

  assign w_load = (r_state == ST_IDLE) && bus.Start && w_mulOp;
  assign w_step = (r_state == ST_RUN) && !bus.Flush;

  shiftadd_mul_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_load   (w_load),
    .i_step   (w_step),
    .i_mcand  (w_magA),
    .i_mplier (w_magB),
    .o_acc    (w_acc),
    .o_last   (w_last)
  );

  // Sign fix-up of the unsigned product, then accumulate into HI/LO.
  always_comb begin
    w_prod   = r_negate ? -w_acc : w_acc;
    w_commit = w_prod;
    case (r_op)
      OP_MADD: w_commit = {r_hi, r_lo} + w_prod;
      OP_MSUB: w_commit = {r_hi, r_lo} - w_prod;
      default: w_commit = w_prod;
    endcase
  end

  // Sequencer FSM. Requests are only looked at in IDLE; Flush beats the FIX
  // commit so an aborted multiply never touches HI/LO.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_NONE;
      r_negate <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.Start) begin
            case (bus.Op)
              OP_MTHI: r_hi <= bus.A;
              OP_MTLO: r_lo <= bus.A;
              OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                r_op     <= op_e'(bus.Op);
                r_negate <= w_negate;
                r_busy   <= 1'b1;
                r_state  <= ST_RUN;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (bus.Flush) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_last) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!bus.Flush) begin
            r_hi   <= w_commit[2*WIDTH-1:WIDTH];
            r_lo   <= w_commit[WIDTH-1:0];
            r_done <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.Busy   = r_busy;
  assign bus.Done   = r_done;
  assign bus.HI_out = r_hi;
  assign bus.LO_out = r_lo;

endmodule

// File: tb/tb_hilo_mul_sequencer.sv
// tb_hilo_mul_sequencer: scoreboard bench for hilo_mul_sequencer.
// Stimulus pushes the expected {HI,LO} and Busy length for each multiply;
// a monitor pops and compares whenever Done is seen.
// Honors EARLY_TERM_EN for the expected Busy length.
module tb_hilo_mul_sequencer;
  import hilo_pkg::*;

  localparam int WIDTH = 32;
`ifdef EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  typedef struct {
    logic [63:0] hilo;
    int          busyCycles;
  } exp_t;

  logic Clk;
  logic Reset;

  hilo_mul_sequencer_if #(.WIDTH(WIDTH)) bus ();

  hilo_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  exp_t        sbQ[$];
  exp_t        monE;
  int          checks   = 0;
  int          failures = 0;
  int          busyCnt  = 0;
  logic [63:0] mHiLo;
  logic [31:0] corners[6];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Reference product straight from signed/unsigned arithmetic.
  function automatic logic [63:0] refProduct(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    if (op == OP_MULTU) return {32'b0, a} * {32'b0, b};
    return sa * sb;
  endfunction

  function automatic logic [31:0] magOf(input logic [31:0] v);
    longint sv = longint'($signed(v));
    if (sv < 0) sv = -sv;
    return sv[31:0];
  endfunction

  // Cycles Busy stays high: fixed WIDTH+1, or with early termination one
  // cycle per significant multiplier bit (capped) plus load and fix-up.
  function automatic int expBusy(input logic [31:0] mag);
    int bitLen = 0;
    int early;
    for (int i = 0; i < WIDTH; i++) if (mag[i]) bitLen = i + 1;
    early = ((bitLen < WIDTH - 1) ? bitLen : WIDTH - 1) + 2;
    return EARLY_TERM ? early : WIDTH + 1;
  endfunction

  // Drives one request for a cycle and updates the reference model.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    bit          isMul;
    isMul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    if (isMul) begin
      p = refProduct(op, a, b);
      if (op == OP_MADD)      mHiLo = mHiLo + p;
      else if (op == OP_MSUB) mHiLo = mHiLo - p;
      else                    mHiLo = p;
      e.hilo       = mHiLo;
      e.busyCycles = expBusy((op == OP_MULTU) ? b : magOf(b));
      sbQ.push_back(e);
    end else if (op == OP_MTHI) begin
      mHiLo[63:32] = a;
    end else if (op == OP_MTLO) begin
      mHiLo[31:0] = a;
    end
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.Op    = OP_NONE;
    if (!isMul) begin
      checkOutput($sformatf("op%0d_hilo", op), {bus.HI_out, bus.LO_out}, mHiLo);
      checkOutput($sformatf("op%0d_busy", op), 64'(bus.Busy), 64'd0);
    end
  endtask

  // Starts a multiply the bench intends to abort; nothing is expected.
  task automatic startRaw(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.Op    = OP_NONE;
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((sbQ.size() != 0 || bus.Busy === 1'b1) && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL timeout: pending=%0d busy=%b, want 0 and 0", sbQ.size(), bus.Busy);
      sbQ.delete();
    end
  endtask

  // Monitor: scores every Done pulse against the oldest expectation and
  // measures how long Busy was high before it.
  always @(negedge Clk) begin
    if (bus.Done === 1'b1) begin
      if (sbQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got Done=1 with nothing pending, want Done=0");
      end else begin
        monE = sbQ.pop_front();
        checkOutput("sb_hilo", {bus.HI_out, bus.LO_out}, monE.hilo);
        checkOutput("sb_busy_cycles", 64'(busyCnt), 64'(monE.busyCycles));
      end
      busyCnt = 0;
    end else if (bus.Busy === 1'b1) begin
      busyCnt++;
    end else begin
      busyCnt = 0;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h0000FFFF};
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Op    = OP_NONE;
    bus.A     = '0;
    bus.B     = '0;
    bus.Flush = 1'b0;
    mHiLo     = '0;

    repeat (3) @(negedge Clk);
    checkOutput("reset_busy", 64'(bus.Busy), 64'd0);
    checkOutput("reset_done", 64'(bus.Done), 64'd0);
    checkOutput("reset_hi", 64'(bus.HI_out), 64'd0);
    checkOutput("reset_lo", 64'(bus.LO_out), 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    $display("[TB] directed multiplies");
    applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd5);
    waitIdle();
    checkOutput("mult_neg3x5", {bus.HI_out, bus.LO_out}, 64'hFFFFFFFF_FFFFFFF1);
    applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitIdle();
    checkOutput("multu_max", {bus.HI_out, bus.LO_out}, 64'hFFFFFFFE_00000001);
    applyStimulus(OP_MULT, 32'h80000000, 32'h80000000);
    waitIdle();
    checkOutput("mult_minxmin", {bus.HI_out, bus.LO_out}, 64'h40000000_00000000);

    $display("[TB] mthi/mtlo then accumulate");
    applyStimulus(OP_MTHI, 32'h0, 32'h0);
    applyStimulus(OP_MTLO, 32'hFFFFFFFF, 32'h0);
    applyStimulus(OP_MADD, 32'd1, 32'd1);
    waitIdle();
    checkOutput("madd_carry", {bus.HI_out, bus.LO_out}, 64'h00000001_00000000);
    applyStimulus(OP_MSUB, 32'd2, 32'd3);
    waitIdle();

    $display("[TB] request while busy is ignored");
    applyStimulus(OP_MULT, 32'd7, 32'd9);
    repeat (4) @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op    = OP_MTLO;
    bus.A     = 32'h1234;
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.Op    = OP_NONE;
    waitIdle();
    checkOutput("ignored_mtlo", {bus.HI_out, bus.LO_out}, 64'd63);

    $display("[TB] flush during run");
    applyStimulus(OP_MTHI, 32'hAA, 32'h0);
    startRaw(OP_MULT, 32'd7, 32'd9);
    repeat (9) @(negedge Clk);
    bus.Flush = 1'b1;
    @(negedge Clk);
    bus.Flush = 1'b0;
    checkOutput("flush_busy", 64'(bus.Busy), 64'd0);
    checkOutput("flush_done", 64'(bus.Done), 64'd0);
    checkOutput("flush_hilo", {bus.HI_out, bus.LO_out}, mHiLo);
    repeat (40) @(negedge Clk);

    $display("[TB] flush during fix-up");
    applyStimulus(OP_MTHI, 32'h55, 32'h0);
    startRaw(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (32) @(negedge Clk);
    checkOutput("fix_busy", 64'(bus.Busy), 64'd1);
    bus.Flush = 1'b1;
    @(negedge Clk);
    bus.Flush = 1'b0;
    checkOutput("fixflush_busy", 64'(bus.Busy), 64'd0);
    checkOutput("fixflush_done", 64'(bus.Done), 64'd0);
    checkOutput("fixflush_hilo", {bus.HI_out, bus.LO_out}, mHiLo);
    repeat (5) @(negedge Clk);

    $display("[TB] reset mid-operation");
    startRaw(OP_MULT, 32'd7, 32'd9);
    repeat (19) @(negedge Clk);
    Reset = 1'b1;
    #1;
    checkOutput("midreset_busy", 64'(bus.Busy), 64'd0);
    checkOutput("midreset_done", 64'(bus.Done), 64'd0);
    checkOutput("midreset_hi", 64'(bus.HI_out), 64'd0);
    checkOutput("midreset_lo", 64'(bus.LO_out), 64'd0);
    mHiLo = '0;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    $display("[TB] flush with start in idle, and no-op codes");
    bus.Flush = 1'b1;
    applyStimulus(OP_MULT, 32'hFFFFFFF0, 32'h00000011);
    bus.Flush = 1'b0;
    waitIdle();
    applyStimulus(OP_NONE, 32'hDEADBEEF, 32'h12345678);
    applyStimulus(OP_RSVD, 32'hCAFEF00D, 32'h87654321);

`ifdef EARLY_TERM_EN
    $display("[TB] early termination");
    applyStimulus(OP_MULT, 32'h1234, 32'h0);
    waitIdle();
    checkOutput("et_zero", {bus.HI_out, bus.LO_out}, 64'h0);
    applyStimulus(OP_MULT, 32'd3, 32'h80000000);
    waitIdle();
    checkOutput("et_full", {bus.HI_out, bus.LO_out}, 64'hFFFFFFFE_80000000);
`endif

    $display("[TB] random operations");
    for (int n = 0; n < 40; n++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(1, 6));
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 4) == 0) b = b & 32'h000000FF;
      applyStimulus(op, a, b);
      waitIdle();
    end

    repeat (3) @(negedge Clk);
    if (sbQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL leftover: got %0d pending results, want 0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
